// File: rtl/ram_dump_ctrl.sv
// Streams a RAM address range out through a valid/ready port, one word per FETCH/LOAD/SEND pass.
// Optional running checksum of accepted words is built when RAM_DUMP_CHECKSUM_EN is defined.
module ram_dump_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_start,
  input  logic [ADDR_WIDTH-1:0] addr_end,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done_tick,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic                    accept;
  logic                    last;

  assign accept = (state == SEND) && dout_ready;
  assign last   = (ram_addr == end_addr);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (dout_ready) state_next = last ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    dout_valid = (state == SEND);
  end

  // Range endpoints are captured at the start edge so later input changes cannot disturb a dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      end_addr  <= '0;
      dout      <= '0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= accept && last;
      case (state)
        IDLE: if (start) begin
          ram_addr <= addr_start;
          end_addr <= addr_end;
        end
        LOAD: dout <= ram_q;
        SEND: if (accept && !last) ram_addr <= ram_addr + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset)                        sum <= '0;
    else if ((state == IDLE) && start) sum <= '0;
    else if (accept)                  sum <= sum + dout;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule
